// File: rtl/hilo_result_unit_pkg.sv
// Shared definitions for the writeback result unit.
//   DEF_WIDTH   : default datapath width
//   DEF_FUNCT_W : default R-type funct field width
//   funct_e     : R-type function codes decoded by the unit
package hilo_result_unit_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_FUNCT_W = 6;

  typedef enum logic [DEF_FUNCT_W-1:0] {
    F_SRL   = 6'b000010,
    F_MFHI  = 6'b010000,
    F_MTHI  = 6'b010001,
    F_MFLO  = 6'b010010,
    F_MTLO  = 6'b010011,
    F_MULTU = 6'b011001,
    F_ADD   = 6'b100000,
    F_SUB   = 6'b100010,
    F_AND   = 6'b100100,
    F_OR    = 6'b100101,
    F_SLT   = 6'b101010
  } funct_e;

endpackage

// File: rtl/hilo_result_unit_mul_iter.sv
// Serial shift-add unsigned multiplier, one multiplier bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : latch a/b and begin (only honoured while idle)
//   a, b       : multiplicand, multiplier
//   done       : high during the cycle whose closing edge completes the product
//   product    : full 2*WIDTH-bit product, valid while done is high
module mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import hilo_result_unit_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {
    M_IDLE,
    M_RUN
  } mstate_e;

  mstate_e              state, state_nx;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  // Upper half accumulates partial products, lower half holds the
  // remaining multiplier bits; both shift right together each step.
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_step;
  logic [CNT_W-1:0]     cnt;

  always_comb begin
    addend   = acc[0] ? mcand : '0;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_step = {sum, acc[WIDTH-1:1]};
  end

  // The final step result is exposed combinationally so the parent can
  // capture HI/LO on the same edge that retires the multiply.
  assign product = acc_step;

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      M_IDLE: if (start) state_nx = M_RUN;
      M_RUN: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          done     = 1'b1;
          state_nx = M_IDLE;
        end
      end
      default: state_nx = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= M_IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        M_IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
          end
        end
        M_RUN: begin
          acc <= acc_step;
          cnt <= done ? '0 : cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/hilo_result_unit.sv
// Writeback result selector with HI/LO register pair and iterative MULTU.
//   clk, rst_n          : clock, asynchronous active-low reset
//   valid_in, ready_out : upstream handshake (ready_out = !busy)
//   funct               : R-type function code
//   alu_out, shift_out  : EX-stage results
//   src_a, src_b        : rs / rt operands (multiply, MTHI/MTLO)
//   data_out, data_valid: registered writeback value and one-cycle strobe
//   busy                : multiply in progress
//   hi_out, lo_out      : current HI / LO
module hilo_result_unit #(
  parameter int unsigned WIDTH   = hilo_result_unit_pkg::DEF_WIDTH,
  parameter int unsigned FUNCT_W = hilo_result_unit_pkg::DEF_FUNCT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [WIDTH-1:0]   shift_out,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_valid,
  output logic               busy,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out
);
  import hilo_result_unit_pkg::*;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   sel_val;
  logic               sel_type;
  logic               is_mthi, is_mtlo, is_mult;
  logic               accept;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign ready_out = !busy;
  assign accept    = valid_in && !busy;
  assign hi_out    = hi;
  assign lo_out    = lo;

  always_comb begin
    sel_val  = '0;
    sel_type = 1'b0;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
    is_mult  = 1'b0;
    case (funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT: begin
        sel_val  = alu_out;
        sel_type = 1'b1;
      end
      F_SRL: begin
        sel_val  = shift_out;
        sel_type = 1'b1;
      end
      F_MFHI: begin
        sel_val  = hi;
        sel_type = 1'b1;
      end
      F_MFLO: begin
        sel_val  = lo;
        sel_type = 1'b1;
      end
      F_MTHI:  is_mthi = 1'b1;
      F_MTLO:  is_mtlo = 1'b1;
      F_MULTU: is_mult = 1'b1;
      // Unrecognised codes still produce a (zero) writeback.
      default: sel_type = 1'b1;
    endcase
  end

  mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mult),
    .a       (src_a),
    .b       (src_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi         <= '0;
      lo         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (accept) begin
        if (sel_type) begin
          data_out   <= sel_val;
          data_valid <= 1'b1;
        end
        if (is_mthi) hi <= src_a;
        if (is_mtlo) lo <= src_a;
        if (is_mult) busy <= 1'b1;
      end
      // accept is blocked while busy, so this never collides with the above.
      if (busy && mul_done) begin
        hi   <= mul_product[2*WIDTH-1:WIDTH];
        lo   <= mul_product[WIDTH-1:0];
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hilo_result_unit.sv
module tb_hilo_result_unit;

  localparam int unsigned W = 32;

  localparam logic [5:0] T_AND   = 6'b100100;
  localparam logic [5:0] T_OR    = 6'b100101;
  localparam logic [5:0] T_ADD   = 6'b100000;
  localparam logic [5:0] T_SUB   = 6'b100010;
  localparam logic [5:0] T_SLT   = 6'b101010;
  localparam logic [5:0] T_SRL   = 6'b000010;
  localparam logic [5:0] T_MFHI  = 6'b010000;
  localparam logic [5:0] T_MFLO  = 6'b010010;
  localparam logic [5:0] T_MTHI  = 6'b010001;
  localparam logic [5:0] T_MTLO  = 6'b010011;
  localparam logic [5:0] T_MULTU = 6'b011001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic         ready_out;
  logic [5:0]   funct;
  logic [W-1:0] alu_out, shift_out, src_a, src_b;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic [W-1:0] hi_out, lo_out;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state
  logic [W-1:0] m_hi, m_lo, m_dout;
  logic         m_dv;

  always #5 clk = ~clk;

  hilo_result_unit #(
    .WIDTH   (W),
    .FUNCT_W (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .funct      (funct),
    .alu_out    (alu_out),
    .shift_out  (shift_out),
    .src_a      (src_a),
    .src_b      (src_b),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_busy);
    chk({tag, ".data_out"},   64'(data_out),   64'(m_dout));
    chk({tag, ".data_valid"}, 64'(data_valid), 64'(m_dv));
    chk({tag, ".hi"},         64'(hi_out),     64'(m_hi));
    chk({tag, ".lo"},         64'(lo_out),     64'(m_lo));
    chk({tag, ".busy"},       64'(busy),       64'(exp_busy));
    chk({tag, ".ready"},      64'(ready_out),  64'(!exp_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_known(input logic [5:0] f);
    return f inside {T_AND, T_OR, T_ADD, T_SUB, T_SLT, T_SRL, T_MFHI,
                     T_MFLO, T_MTHI, T_MTLO, T_MULTU};
  endfunction

  // Non-multiply op: one accepting edge, then compare against the model.
  task automatic do_op(input string tag, input logic [5:0] f,
                       input logic [W-1:0] alu, input logic [W-1:0] sh,
                       input logic [W-1:0] a);
    funct = f; alu_out = alu; shift_out = sh; src_a = a; src_b = $urandom;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    if (f inside {T_AND, T_OR, T_ADD, T_SUB, T_SLT}) begin m_dout = alu; m_dv = 1'b1; end
    else if (f == T_SRL)  begin m_dout = sh;   m_dv = 1'b1; end
    else if (f == T_MFHI) begin m_dout = m_hi; m_dv = 1'b1; end
    else if (f == T_MFLO) begin m_dout = m_lo; m_dv = 1'b1; end
    else if (f == T_MTHI) begin m_hi = a; m_dv = 1'b0; end
    else if (f == T_MTLO) begin m_lo = a; m_dv = 1'b0; end
    else begin m_dout = '0; m_dv = 1'b1; end
    check_all(tag, 1'b0);
  endtask

  task automatic idle(input string tag);
    valid_in = 1'b0;
    step();
    m_dv = 1'b0;
    check_all(tag, 1'b0);
  endtask

  // MULTU; optionally keep MFHI presented with valid_in held while busy.
  task automatic do_multu(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hold_mfhi);
    int n;
    funct = T_MULTU; src_a = a; src_b = b; alu_out = $urandom; shift_out = $urandom;
    valid_in = 1'b1;
    step();
    if (hold_mfhi) funct = T_MFHI;
    else valid_in = 1'b0;
    m_dv = 1'b0;
    check_all({tag, ".start"}, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      step();
      n++;
      if (busy === 1'b1) begin
        chk({tag, ".dv_busy"}, 64'(data_valid), 64'd0);
        chk({tag, ".hi_hold"}, 64'(hi_out), 64'(m_hi));
        chk({tag, ".lo_hold"}, 64'(lo_out), 64'(m_lo));
      end
    end
    chk({tag, ".cycles"}, 64'(n), 64'(W));
    {m_hi, m_lo} = 64'(a) * 64'(b);
    check_all({tag, ".done"}, 1'b0);
    if (hold_mfhi) begin
      step();
      valid_in = 1'b0;
      m_dout = m_hi;
      m_dv = 1'b1;
      check_all({tag, ".held_mfhi"}, 1'b0);
    end
  endtask

  initial begin
    logic [5:0] f;
    int r;
    rst_n = 1'b0; valid_in = 1'b0; funct = '0;
    alu_out = '0; shift_out = '0; src_a = '0; src_b = '0;
    m_hi = '0; m_lo = '0; m_dout = '0; m_dv = 1'b0;
    #12;
    check_all("reset", 1'b0);
    #1 rst_n = 1'b1;

    // ADD then idle
    do_op("add", T_ADD, 32'h0000_0005, 32'h0, 32'h0);
    chk("add.value", 64'(data_out), 64'h5);
    idle("add.idle");

    // Full-scale multiply, MFHI held across the busy window
    do_multu("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("mul_ff.mfhi", 64'(data_out), 64'hFFFF_FFFE);
    do_op("mfl_ff", T_MFLO, $urandom, $urandom, $urandom);
    chk("mul_ff.mflo", 64'(data_out), 64'h1);

    // MTLO then MFLO
    do_op("mtlo", T_MTLO, $urandom, $urandom, 32'h1234_5678);
    do_op("mflo", T_MFLO, $urandom, $urandom, $urandom);
    chk("mflo.value", 64'(data_out), 64'h1234_5678);

    // Reset in the middle of a multiply
    do_op("mthi_pre", T_MTHI, $urandom, $urandom, 32'hAAAA_AAAA);
    funct = T_MULTU; src_a = 32'd7; src_b = 32'd9; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (10) step();
    chk("pre_rst.busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0; m_dout = '0; m_dv = 1'b0;
    check_all("mid_rst", 1'b0);
    #1 rst_n = 1'b1;
    do_multu("mul_7x9", 32'd7, 32'd9, 1'b0);
    chk("mul_7x9.lo", 64'(lo_out), 64'd63);
    chk("mul_7x9.hi", 64'(hi_out), 64'd0);

    // Unknown funct and SRL
    do_op("unk", 6'b111111, 32'hDEAD_BEEF, 32'hCAFE_F00D, $urandom);
    chk("unk.value", 64'(data_out), 64'd0);
    do_op("srl", T_SRL, $urandom, 32'h8000_0000, $urandom);
    chk("srl.value", 64'(data_out), 64'h8000_0000);

    // Back-to-back multiplies
    do_multu("b2b0", $urandom, $urandom, 1'b0);
    do_multu("b2b1", $urandom, $urandom, 1'b0);

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 13);
      case (r)
        0:  do_op("r_and",  T_AND,  $urandom, $urandom, $urandom);
        1:  do_op("r_or",   T_OR,   $urandom, $urandom, $urandom);
        2:  do_op("r_add",  T_ADD,  $urandom, $urandom, $urandom);
        3:  do_op("r_sub",  T_SUB,  $urandom, $urandom, $urandom);
        4:  do_op("r_slt",  T_SLT,  $urandom, $urandom, $urandom);
        5:  do_op("r_srl",  T_SRL,  $urandom, $urandom, $urandom);
        6:  do_op("r_mfhi", T_MFHI, $urandom, $urandom, $urandom);
        7:  do_op("r_mflo", T_MFLO, $urandom, $urandom, $urandom);
        8:  do_op("r_mthi", T_MTHI, $urandom, $urandom, $urandom);
        9:  do_op("r_mtlo", T_MTLO, $urandom, $urandom, $urandom);
        10: do_multu("r_mul", $urandom, $urandom, ($urandom_range(0, 1) == 1));
        11: begin
          f = 6'b111111;
          for (int k = 0; k < 20; k++) begin
            f = 6'($urandom_range(0, 63));
            if (!is_known(f)) break;
          end
          if (is_known(f)) f = 6'b111111;
          do_op("r_unk", f, $urandom, $urandom, $urandom);
        end
        default: idle("r_idle");
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/hilo_result_unit.md
Name: hilo_result_unit

Overview:
- Parametrised successor to the writeback result selector.
- Selects the GPR writeback source (ALU, shifter, HI, LO) from the R-type funct code and registers the result.
- Owns the HI/LO register pair and a multi-cycle iterative unsigned multiplier (MULTU); supports MTHI/MTLO.
- Sits between the EX-stage datapath (ALU, shifter) and register-file write; stalls upstream through a ready/busy handshake.

Parameters:
WIDTH, 32, datapath width of all operands, HI, LO and data_out
FUNCT_W, 6, width of funct select
CNT_W, $clog2(WIDTH)+1, multiply step counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  funct/operands valid this cycle
ready_out  out  1  unit can accept; combinational, equals !busy
funct  in  FUNCT_W  R-type function code
alu_out  in  WIDTH  ALU result
shift_out  in  WIDTH  shifter result
src_a  in  WIDTH  rs operand (multiplicand, MTHI/MTLO source)
src_b  in  WIDTH  rt operand (multiplier)
data_out  out  WIDTH  registered writeback value
data_valid  out  1  data_out valid for GPR write, one-cycle pulse
busy  out  1  multiply in progress
hi_out  out  WIDTH  current HI register
lo_out  out  WIDTH  current LO register

Behaviour:
- Reset (async, rst_n=0): hi, lo, data_out, data_valid, busy, step counter, multiplier internals all 0. A reset mid-multiply aborts; HI/LO read 0 afterwards.
- Accept = valid_in && ready_out at a rising edge. valid_in while busy is ignored; upstream holds.
- Funct codes: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010 -> alu_out; SRL 000010 -> shift_out; MFHI 010000 -> hi; MFLO 010010 -> lo; MTHI 010001; MTLO 010011; MULTU 011001. Any other code -> data_out=0, data_valid=1.
- Select-type ops (ALU, SRL, MFHI, MFLO, unknown): latency 1. data_out/data_valid update at the accepting edge; data_valid drops next edge unless another select-type op is accepted.
- MTHI/MTLO: hi (or lo) <= src_a at the accepting edge; data_valid=0; data_out holds.
- MULTU: accepted at edge k.
  - Operands are latched and busy=1 after edge k.
  - Shift-add, one multiplier bit per edge, on edges k+1 .. k+WIDTH.
  - At edge k+WIDTH: {hi,lo} <= 2*WIDTH-bit unsigned product and busy=0.
  - data_valid stays 0 throughout; HI/LO hold their old values until completion.
- Earliest MFHI after MULTU: accepted at edge k+WIDTH+1, returning the new product half.
- A select op accepted in the same edge as MULTU is impossible (one funct per cycle); a MULTU immediately following completion is accepted normally.
- No overflow or exception: the product is always exact, 2*WIDTH bits.
- Counter wraps to 0 at completion; a back-to-back MULTU restarts cleanly.

Decomposition:
- Shared package: funct code constants (above), default WIDTH.
- Sub-module mul_iter: serial shift-add unsigned multiplier.
  - Inputs: start, a, b.
  - Outputs: done pulse, product[2*WIDTH-1:0].
- The parent holds HI/LO, the select mux, the output register and the handshake.

Test Plan:
- Reset then ADD with alu_out=0x0000_0005, valid_in=1 -> next edge data_out=5, data_valid=1; following idle cycle data_valid=0.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> busy high 32 cycles, ready_out low; then MFHI -> 0xFFFF_FFFE, MFLO -> 0x0000_0001.
- MFHI presented with valid_in held while busy -> not accepted until busy=0; returns new HI, never stale.
- MTLO src_a=0x1234_5678 then MFLO -> data_out=0x1234_5678; data_valid=0 on the MTLO cycle.
- Reset asserted at step 10 of MULTU 7*9 -> busy=0, hi=lo=0 immediately; subsequent MULTU 7*9 -> lo=63, hi=0.
- Unknown funct 111111 -> data_out=0, data_valid=1; SRL with shift_out=0x8000_0000 -> 0x8000_0000.
